// File: rtl/ibex_pkg.sv
// Shared types for the register-file write arbiter.
package ibex_pkg;

    typedef enum logic {
        RfArbClear = 1'b0,
        RfArbRun   = 1'b1
    } rf_arb_state_e;

endpackage

// File: rtl/ibex_rf_wr_arbiter.sv
// Arbitrates the single register-file write port between writeback and late LSU loads,
// and zeroes the register file after reset or on request.
module ibex_rf_wr_arbiter
    import ibex_pkg::*;
#(
    parameter bit          RV32E       = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned StarveLimit = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_req_i,

    input  logic                 wb_we_i,
    input  logic [4:0]           wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic                 wb_ready_o,

    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_gnt_o,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 init_done_o
);

    localparam int unsigned NumWords    = RV32E ? 16 : 32;
    localparam int unsigned AddrWidth   = $clog2(NumWords);
    localparam int unsigned StarveWidth = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;

    rf_arb_state_e          state_q;
    logic [AddrWidth-1:0]   clr_cnt_q;
    logic [StarveWidth-1:0] starve_q;

    logic run;
    logic clr_last;
    logic starved;
    logic wb_win;
    logic lsu_win;

    assign run      = rst_ni && (state_q == RfArbRun);
    assign clr_last = (clr_cnt_q == AddrWidth'(NumWords - 1));
    assign starved  = (starve_q == StarveWidth'(StarveLimit));
    assign wb_win   = run && wb_we_i && !starved;
    assign lsu_win  = run && lsu_req_i && !wb_win;

    // Outputs are gated by rst_ni so they read zero for the whole reset cycle.
    always_comb begin
        wb_ready_o  = 1'b0;
        lsu_gnt_o   = 1'b0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        init_done_o = 1'b0;
        if (rst_ni) begin
            if (state_q == RfArbClear) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = 5'(clr_cnt_q);
            end else begin
                init_done_o = 1'b1;
                wb_ready_o  = !starved;
                lsu_gnt_o   = lsu_win;
                if (wb_win) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = wb_waddr_i;
                    rf_wdata_o = wb_wdata_i;
                end else if (lsu_win) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = lsu_waddr_i;
                    rf_wdata_o = lsu_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RfArbClear;
            clr_cnt_q <= AddrWidth'(1);
            starve_q  <= '0;
        end else begin
            case (state_q)
                RfArbClear: begin
                    clr_cnt_q <= clr_cnt_q + AddrWidth'(1);
                    starve_q  <= '0;
                    if (clr_last) begin
                        state_q <= RfArbRun;
                    end
                end
                default: begin
                    if (clear_req_i) begin
                        state_q   <= RfArbClear;
                        clr_cnt_q <= AddrWidth'(1);
                    end
                    if (!lsu_req_i || lsu_win) begin
                        starve_q <= '0;
                    end else if (!starved) begin
                        starve_q <= starve_q + StarveWidth'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Bench for ibex_rf_wr_arbiter: directed vectors, clear/reset sequences and a random run
// compared against a behavioural model.
module tb_ibex_rf_wr_arbiter;

    localparam int LIMIT = 3;
    localparam int NW    = 32;

    logic        clk;
    logic        rst_n, clear_req, wb_we, lsu_req;
    logic [4:0]  wb_waddr, lsu_waddr;
    logic [31:0] wb_wdata, lsu_wdata;
    logic        wb_ready, lsu_gnt, rf_we, init_done;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        e_rst_n;
    logic        e_wb_ready, e_lsu_gnt, e_rf_we, e_init_done;
    logic [4:0]  e_rf_waddr;
    logic [31:0] e_rf_wdata;

    int total = 0;
    int bad   = 0;

    // model state: m_clear = next clear address (0 while running), m_deny = consecutive LSU denials
    int   m_clear = 1;
    int   m_deny  = 0;
    logic x_we, x_ready, x_gnt, x_done;
    logic [4:0]  x_addr;
    logic [31:0] x_data;

    ibex_rf_wr_arbiter #(.RV32E(1'b0), .DataWidth(32), .StarveLimit(LIMIT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_req_i(clear_req),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata), .wb_ready_o(wb_ready),
        .lsu_req_i(lsu_req), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .init_done_o(init_done)
    );

    ibex_rf_wr_arbiter #(.RV32E(1'b1), .DataWidth(32), .StarveLimit(LIMIT)) dut_e (
        .clk_i(clk), .rst_ni(e_rst_n), .clear_req_i(1'b0),
        .wb_we_i(1'b0), .wb_waddr_i(5'd0), .wb_wdata_i(32'd0), .wb_ready_o(e_wb_ready),
        .lsu_req_i(1'b0), .lsu_waddr_i(5'd0), .lsu_wdata_i(32'd0), .lsu_gnt_o(e_lsu_gnt),
        .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata), .init_done_o(e_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lr;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_gnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive inputs just after the falling edge, then compare every output with the model.
    task automatic apply(input logic rst, input logic clr, input logic wwe, input logic [4:0] wa,
                         input logic [31:0] wd, input logic lr, input logic [4:0] la,
                         input logic [31:0] ld);
        rst_n = rst; clear_req = clr;
        wb_we = wwe; wb_waddr = wa; wb_wdata = wd;
        lsu_req = lr; lsu_waddr = la; lsu_wdata = ld;
        #1;
        x_we = 0; x_addr = 0; x_data = 0; x_ready = 0; x_gnt = 0; x_done = 0;
        if (rst) begin
            if (m_clear != 0) begin
                x_we   = 1;
                x_addr = 5'(m_clear);
            end else begin
                x_done  = 1;
                x_ready = (m_deny < LIMIT);
                if (wwe && x_ready) begin
                    x_we = 1; x_addr = wa; x_data = wd;
                end else if (lr) begin
                    x_gnt = 1; x_we = 1; x_addr = la; x_data = ld;
                end
            end
        end
        chk("rf_we", rf_we, x_we);
        chk("rf_waddr", rf_waddr, x_addr);
        chk("rf_wdata", rf_wdata, x_data);
        chk("wb_ready", wb_ready, x_ready);
        chk("lsu_gnt", lsu_gnt, x_gnt);
        chk("init_done", init_done, x_done);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_clear = 1;
            m_deny  = 0;
        end else if (m_clear != 0) begin
            m_clear = (m_clear == NW - 1) ? 0 : m_clear + 1;
            m_deny  = 0;
        end else begin
            if (lsu_req && !x_gnt) m_deny = (m_deny + 1 > LIMIT) ? LIMIT : m_deny + 1;
            else m_deny = 0;
            if (clear_req) m_clear = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1, 5'd5,  32'hDEADBEEF, 1, 5'd6,  32'h66,   1, 5'd5,  32'hDEADBEEF, 1, 0};
        vecs[1] = '{0, 5'd0,  32'd0,        0, 5'd0,  32'd0,    0, 5'd0,  32'd0,        1, 0};
        vecs[2] = '{0, 5'd9,  32'hFFFF,     1, 5'd0,  32'h1234, 1, 5'd0,  32'h1234,     1, 1};
        vecs[3] = '{1, 5'd10, 32'hA,        1, 5'd11, 32'hB,    1, 5'd10, 32'hA,        1, 0};
        vecs[4] = '{1, 5'd10, 32'hA,        1, 5'd11, 32'hB,    1, 5'd10, 32'hA,        1, 0};
        vecs[5] = '{1, 5'd10, 32'hA,        1, 5'd11, 32'hB,    1, 5'd10, 32'hA,        1, 0};
        vecs[6] = '{1, 5'd10, 32'hA,        1, 5'd11, 32'hB,    1, 5'd11, 32'hB,        0, 1};
        vecs[7] = '{1, 5'd10, 32'hA,        1, 5'd11, 32'hB,    1, 5'd10, 32'hA,        1, 0};
        vecs[8] = '{1, 5'd0,  32'h55,       0, 5'd0,  32'd0,    1, 5'd0,  32'h55,       1, 0};
        vecs[9] = '{0, 5'd0,  32'd0,        1, 5'd31, 32'h77,   1, 5'd31, 32'h77,       1, 1};

        e_rst_n = 0;
        rst_n = 0; clear_req = 0; wb_we = 0; lsu_req = 0;
        wb_waddr = 0; wb_wdata = 0; lsu_waddr = 0; lsu_wdata = 0;
        @(negedge clk);

        // Reset with requests pending: everything must read zero
        apply(0, 1, 1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
        tick();
        // Clear sweep after reset release
        for (int i = 1; i <= 31; i++) begin
            idle();
            chk("clr_addr", rf_waddr, i);
            chk("clr_we", rf_we, 1);
            tick();
        end
        idle();
        chk("done_after_clear", init_done, 1);
        tick();

        foreach (vecs[k]) begin
            apply(1, 0, vecs[k].wwe, vecs[k].wa, vecs[k].wd, vecs[k].lr, vecs[k].la, vecs[k].ld);
            chk("vec_we", rf_we, vecs[k].e_we);
            chk("vec_addr", rf_waddr, vecs[k].e_addr);
            chk("vec_data", rf_wdata, vecs[k].e_data);
            chk("vec_ready", wb_ready, vecs[k].e_ready);
            chk("vec_gnt", lsu_gnt, vecs[k].e_gnt);
            tick();
        end

        // Clear request alongside a writeback: write goes through, then a full re-clear
        apply(1, 1, 1, 5'd7, 32'hCAFE, 0, 5'd0, 32'd0);
        chk("clrreq_addr", rf_waddr, 7);
        chk("clrreq_data", rf_wdata, 32'hCAFE);
        tick();
        for (int i = 1; i <= 31; i++) begin
            apply(1, 1, 1, 5'd7, 32'hCAFE, 1, 5'd8, 32'h8);
            chk("reclr_addr", rf_waddr, i);
            chk("reclr_ready", wb_ready, 0);
            chk("reclr_gnt", lsu_gnt, 0);
            tick();
        end
        idle();
        chk("reclr_done", init_done, 1);
        tick();

        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
            tick();
        end

        // RV32E instance: reset while address 9 is being cleared
        e_rst_n = 0;
        @(posedge clk); @(negedge clk);
        e_rst_n = 1;
        for (int i = 1; i <= 9; i++) begin
            #1;
            chk("e_addr", e_rf_waddr, i);
            if (i != 9) begin
                @(posedge clk); @(negedge clk);
            end
        end
        e_rst_n = 0;
        #1;
        chk("e_rst_we", e_rf_we, 0);
        chk("e_rst_addr", e_rf_waddr, 0);
        chk("e_rst_ready", e_wb_ready, 0);
        chk("e_rst_done", e_init_done, 0);
        @(posedge clk); @(negedge clk);
        e_rst_n = 1;
        for (int i = 1; i <= 15; i++) begin
            #1;
            chk("e_reclr_addr", e_rf_waddr, i);
            chk("e_reclr_we", e_rf_we, 1);
            chk("e_reclr_done", e_init_done, 0);
            @(posedge clk); @(negedge clk);
        end
        #1;
        chk("e_done", e_init_done, 1);
        chk("e_idle_we", e_rf_we, 0);
        chk("e_ready", e_wb_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
